// File: rtl/pp_pipeline_accel_mul_pipe_nstage.sv
// N-stage pipelined multiplier with valid tracking, ce stall, signed/unsigned mode and
// fixed-point right shift. Define PP_MUL_ROUND_SAT_EN for round-half-up plus saturation.
module pp_pipeline_accel_mul_pipe_nstage #(
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 31,
   parameter int din1_WIDTH = 21,
   parameter int dout_WIDTH = 52,
   parameter int SIGNED     = 0,
   parameter int SHIFT      = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);

   // Handshake: in_valid is sampled only on ce=1 edges and travels with its operands;
   // out_valid qualifies dout. No backpressure exists: ce=0 freezes the whole pipe.
   localparam int P  = din0_WIDTH + din1_WIDTH;
   localparam int EW = ((P > dout_WIDTH) ? P : dout_WIDTH) + 2;
   localparam int ND = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

   logic [din0_WIDTH-1:0] op_a;
   logic [din1_WIDTH-1:0] op_b;
   logic                  sx_a;
   logic                  sx_b;
   logic [EW-1:0]         a_ext;
   logic [EW-1:0]         b_ext;
   logic [EW-1:0]         prod;
   logic [dout_WIDTH-1:0] post_res;
   logic [dout_WIDTH-1:0] res_q [ND];
   logic [NUM_STAGE-1:0]  vld_q;

   generate
      if (NUM_STAGE > 1) begin : g_opreg
         logic [din0_WIDTH-1:0] a_q;
         logic [din1_WIDTH-1:0] b_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_q <= '0;
               b_q <= '0;
            end else if (ce) begin
               a_q <= din0;
               b_q <= din1;
            end
         end
         assign op_a = a_q;
         assign op_b = b_q;
      end else begin : g_noreg
         assign op_a = din0;
         assign op_b = din1;
      end
   endgenerate

   // Operands are extended to EW bits first; unsigned values then have a zero top bit,
   // so one arithmetic shift serves both modes.
   assign sx_a  = (SIGNED != 0) && op_a[din0_WIDTH-1];
   assign sx_b  = (SIGNED != 0) && op_b[din1_WIDTH-1];
   assign a_ext = {{(EW-din0_WIDTH){sx_a}}, op_a};
   assign b_ext = {{(EW-din1_WIDTH){sx_b}}, op_b};
   assign prod  = a_ext * b_ext;

`ifdef PP_MUL_ROUND_SAT_EN
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [EW-1:0] RND = (SHIFT > 0) ? (EW'(1) << RSH) : '0;
   localparam logic signed [EW-1:0] LIM_HI = (SIGNED != 0) ?
      ((EW'(1) << (dout_WIDTH-1)) - EW'(1)) : ((EW'(1) << dout_WIDTH) - EW'(1));
   localparam logic signed [EW-1:0] LIM_LO = (SIGNED != 0) ? ~LIM_HI : '0;

   logic [EW-1:0]        rsum;
   logic signed [EW-1:0] r_full;
   logic                 post_ovf;
   logic                 ovf_q [ND];

   always_comb begin
      rsum     = prod + RND;
      r_full   = $signed(rsum) >>> SHIFT;
      post_res = r_full[dout_WIDTH-1:0];
      post_ovf = 1'b0;
      if (r_full > LIM_HI) begin
         post_res = LIM_HI[dout_WIDTH-1:0];
         post_ovf = 1'b1;
      end else if (r_full < LIM_LO) begin
         post_res = LIM_LO[dout_WIDTH-1:0];
         post_ovf = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ND; i++) ovf_q[i] <= 1'b0;
      end else if (ce) begin
         ovf_q[0] <= post_ovf;
         for (int i = 1; i < ND; i++) ovf_q[i] <= ovf_q[i-1];
      end
   end

   assign ovf = ovf_q[ND-1];
`else
   always_comb begin
      post_res = dout_WIDTH'($signed(prod) >>> SHIFT);
   end

   assign ovf = 1'b0;
`endif

   // res_q[0] is the post-process stage; the rest are pure delay to reach NUM_STAGE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < ND; i++) res_q[i] <= '0;
      end else if (ce) begin
         vld_q[0] <= in_valid;
         for (int i = 1; i < NUM_STAGE; i++) vld_q[i] <= vld_q[i-1];
         res_q[0] <= post_res;
         for (int i = 1; i < ND; i++) res_q[i] <= res_q[i-1];
      end
   end

   assign out_valid = vld_q[NUM_STAGE-1];
   assign dout      = res_q[ND-1];

endmodule
